// File: rtl/ariane_pkg.sv
// Shared FLU scheduling types: instruction classes, scheduler FSM states and a
// saturating-increment helper for the optional stall counters.
package ariane_pkg;

  typedef enum logic [2:0] {
    FLU_ALU    = 3'd0,
    FLU_BRANCH = 3'd1,
    FLU_CSR    = 3'd2,
    FLU_MULT   = 3'd3,
    FLU_DIV    = 3'd4
  } flu_class_t;

  typedef enum logic {
    SCHED_IDLE     = 1'b0,
    SCHED_DIV_BUSY = 1'b1
  } flu_sched_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/flu_issue_scheduler_resv_line.sv
// flu_resv_line: shift-down writeback reservation line with a trans_id payload.
// Entry 0 is the port owner this cycle; a set lands in the top entry after the shift.
module flu_resv_line #(
  parameter int DEPTH = 1,
  parameter int IDW   = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  input  logic           set_i,
  input  logic [IDW-1:0] set_id_i,
  output logic           head_vld_o,
  output logic [IDW-1:0] head_id_o,
  output logic           empty_o
);

  logic [DEPTH-1:0]          vld_q, vld_d;
  logic [DEPTH-1:0][IDW-1:0] id_q, id_d;

  always_comb begin
    vld_d = '0;
    id_d  = '0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      vld_d[k] = vld_q[k+1];
      id_d[k]  = id_q[k+1];
    end
    if (set_i) begin
      vld_d[DEPTH-1] = 1'b1;
      id_d[DEPTH-1]  = set_id_i;
    end
    if (flush_i) begin
      vld_d = '0;
      id_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
    end
  end

  assign head_vld_o = vld_q[0];
  assign head_id_o  = id_q[0];
  assign empty_o    = ~|vld_q;

endmodule

// File: rtl/flu_issue_scheduler.sv
// FLU issue scheduler: one grant per cycle, writeback-slot reservation, divider
// serialisation with watchdog, CSR gating. FLU_SCHED_PERF_EN adds stall counters.
module flu_issue_scheduler
  import ariane_pkg::*;
#(
  parameter int MULT_LAT      = 1,
  parameter int TRANS_ID_BITS = 3,
  parameter int DIV_TIMEOUT   = 127
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     req_valid_i,
  input  logic [2:0]               req_class_i,
  input  logic [TRANS_ID_BITS-1:0] req_trans_id_i,
  output logic                     grant_o,
  output logic                     flu_ready_o,
  input  logic                     csr_commit_i,
  input  logic                     div_done_i,
  output logic                     wb_valid_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic                     div_busy_o,
  output logic                     csr_pending_o,
`ifdef FLU_SCHED_PERF_EN
  output logic [31:0]              stall_csr_o,
  output logic [31:0]              stall_div_o,
  output logic [31:0]              stall_port_o,
`endif
  output logic                     div_timeout_o
);

  localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);

  flu_sched_state_t         state_q, state_d;
  logic [CNT_W-1:0]         div_cnt_q, div_cnt_d;
  logic [TRANS_ID_BITS-1:0] div_id_q, div_id_d;
  logic                     csr_pend_q, csr_pend_d;
  logic                     res_head, res_empty;
  logic [TRANS_ID_BITS-1:0] res_head_id;
  logic                     idle, class_ok, div_fire, div_wb;

  assign idle = (state_q == SCHED_IDLE);

  always_comb begin
    class_ok = 1'b0;
    case (req_class_i)
      FLU_ALU, FLU_BRANCH: class_ok = ~res_head;
      FLU_CSR:             class_ok = ~res_head & ~csr_pend_q;
      // With one grant per cycle nothing can already own the slot MULT_LAT ahead.
      FLU_MULT:            class_ok = 1'b1;
      FLU_DIV:             class_ok = res_empty;
      default:             class_ok = 1'b0;
    endcase
  end

  assign grant_o     = ~rst_i & req_valid_i & class_ok & ~flush_i & idle;
  assign flu_ready_o = ~rst_i & ~flush_i & idle;

  flu_resv_line #(
    .DEPTH (MULT_LAT),
    .IDW   (TRANS_ID_BITS)
  ) u_resv (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .set_i      (grant_o && req_class_i == FLU_MULT),
    .set_id_i   (req_trans_id_i),
    .head_vld_o (res_head),
    .head_id_o  (res_head_id),
    .empty_o    (res_empty)
  );

  assign div_wb        = ~idle & div_done_i;
  assign div_fire      = ~idle & ~div_done_i & (div_cnt_q == CNT_W'(DIV_TIMEOUT));
  assign div_timeout_o = ~rst_i & ~flush_i & div_fire;
  assign wb_valid_o    = ~rst_i & (res_head | div_wb);

  always_comb begin
    wb_trans_id_o = '0;
    if (!rst_i) begin
      if (res_head)    wb_trans_id_o = res_head_id;
      else if (div_wb) wb_trans_id_o = div_id_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    div_id_d  = div_id_q;
    case (state_q)
      SCHED_IDLE: begin
        if (grant_o && req_class_i == FLU_DIV) begin
          state_d   = SCHED_DIV_BUSY;
          div_id_d  = req_trans_id_i;
          div_cnt_d = '0;
        end
      end
      SCHED_DIV_BUSY: begin
        div_cnt_d = div_cnt_q + CNT_W'(1);
        if (div_done_i || div_fire) state_d = SCHED_IDLE;
      end
      default: state_d = SCHED_IDLE;
    endcase
    if (flush_i) begin
      state_d   = SCHED_IDLE;
      div_cnt_d = '0;
    end
  end

  // A commit only retires an entry that was already pending; a same-cycle grant wins.
  always_comb begin
    csr_pend_d = csr_pend_q;
    if (flush_i)                                  csr_pend_d = 1'b0;
    else if (grant_o && req_class_i == FLU_CSR)   csr_pend_d = 1'b1;
    else if (csr_commit_i)                        csr_pend_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= SCHED_IDLE;
      div_cnt_q  <= '0;
      div_id_q   <= '0;
      csr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      div_id_q   <= div_id_d;
      csr_pend_q <= csr_pend_d;
    end
  end

  assign div_busy_o    = ~idle;
  assign csr_pending_o = csr_pend_q;

`ifdef FLU_SCHED_PERF_EN
  logic [31:0] st_csr_q, st_div_q, st_port_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_csr_q  <= '0;
      st_div_q  <= '0;
      st_port_q <= '0;
    end else if (req_valid_i && !grant_o) begin
      if (!idle)
        st_div_q <= sat_inc32(st_div_q);
      else if (req_class_i == FLU_CSR && csr_pend_q)
        st_csr_q <= sat_inc32(st_csr_q);
      else if (!flush_i && !class_ok && req_class_i <= FLU_DIV)
        st_port_q <= sat_inc32(st_port_q);
    end
  end

  assign stall_csr_o  = st_csr_q;
  assign stall_div_o  = st_div_q;
  assign stall_port_o = st_port_q;
`endif

endmodule

// File: tb/tb_flu_issue_scheduler.sv
// Scoreboard bench for flu_issue_scheduler: directed scenarios then random traffic,
// checked against a cycle-indexed writeback-calendar model.
module tb_flu_issue_scheduler;
  localparam int ML = 1;
  localparam int TB = 3;
  localparam int DT = 127;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i = 1'b1, flush_i = 1'b0, req_valid_i = 1'b0;
  logic [2:0]    req_class_i = '0;
  logic [TB-1:0] req_trans_id_i = '0;
  logic          csr_commit_i = 1'b0, div_done_i = 1'b0;
  logic          grant_o, flu_ready_o, wb_valid_o, div_busy_o, csr_pending_o, div_timeout_o;
  logic [TB-1:0] wb_trans_id_o;

  flu_issue_scheduler #(.MULT_LAT(ML), .TRANS_ID_BITS(TB), .DIV_TIMEOUT(DT)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .req_valid_i(req_valid_i),
    .req_class_i(req_class_i), .req_trans_id_i(req_trans_id_i), .grant_o(grant_o),
    .flu_ready_o(flu_ready_o), .csr_commit_i(csr_commit_i), .div_done_i(div_done_i),
    .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o), .div_busy_o(div_busy_o),
    .csr_pending_o(csr_pending_o), .div_timeout_o(div_timeout_o)
  );

  typedef struct {
    int            cyc;
    logic          grant, ready, wbv, busy, csr, tmo;
    logic [TB-1:0] wbid;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Model: absolute-cycle writeback calendar plus divider/CSR bookkeeping.
  int            now = 0;
  logic [TB-1:0] wb_at[int];
  bit            m_busy = 1'b0, m_csr = 1'b0;
  int            m_start = 0;
  logic [TB-1:0] m_div_id = '0;

  task automatic step(input int r, input int f, input int v, input int c, input int id,
                      input int cm, input int dn);
    exp_t e;
    bit port, ok, g, tmo;
    @(posedge clk);
    #1;
    rst_i = (r != 0); flush_i = (f != 0); req_valid_i = (v != 0);
    req_class_i = 3'(c); req_trans_id_i = TB'(id);
    csr_commit_i = (cm != 0); div_done_i = (dn != 0);

    port = wb_at.exists(now);
    case (c)
      0, 1:    ok = !port;
      2:       ok = !port && !m_csr;
      3:       ok = 1'b1;
      4:       ok = (wb_at.num() == 0);
      default: ok = 1'b0;
    endcase
    g   = (r == 0) && (v != 0) && ok && (f == 0) && !m_busy;
    tmo = (r == 0) && (f == 0) && m_busy && (dn == 0) && (now - m_start - 1 == DT);

    e.cyc   = now;
    e.grant = g;
    e.ready = (r == 0) && (f == 0) && !m_busy;
    e.wbv   = (r == 0) && (port || (m_busy && dn != 0));
    e.wbid  = '0;
    if (r == 0) begin
      if (port)                     e.wbid = wb_at[now];
      else if (m_busy && dn != 0)   e.wbid = m_div_id;
    end
    e.busy = m_busy;
    e.csr  = m_csr;
    e.tmo  = tmo;
    sb.push_back(e);

    if (r != 0 || f != 0) begin
      wb_at.delete();
      m_busy = 1'b0;
      m_csr  = 1'b0;
    end else begin
      if (g && c == 3) wb_at[now + ML] = TB'(id);
      if (m_busy && (dn != 0 || tmo)) m_busy = 1'b0;
      if (g && c == 4) begin m_busy = 1'b1; m_start = now; m_div_id = TB'(id); end
      if (g && c == 2) m_csr = 1'b1;
      else if (cm != 0) m_csr = 1'b0;
      if (wb_at.exists(now)) wb_at.delete(now);
    end
    now++;
  endtask

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("grant",       e.cyc, 32'(grant_o),       32'(e.grant));
        chk("flu_ready",   e.cyc, 32'(flu_ready_o),   32'(e.ready));
        chk("wb_valid",    e.cyc, 32'(wb_valid_o),    32'(e.wbv));
        chk("wb_trans_id", e.cyc, 32'(wb_trans_id_o), 32'(e.wbid));
        chk("div_busy",    e.cyc, 32'(div_busy_o),    32'(e.busy));
        chk("csr_pending", e.cyc, 32'(csr_pending_o), 32'(e.csr));
        chk("div_timeout", e.cyc, 32'(div_timeout_o), 32'(e.tmo));
      end
    end
  end

  initial begin : stim
    int c;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // MULT then ALU conflict on the writeback slot
    step(0, 0, 1, 3, 2, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    // CSR gating and commit
    step(0, 0, 1, 2, 1, 0, 0);
    step(0, 0, 1, 2, 3, 0, 0);
    step(0, 0, 1, 2, 3, 1, 0);
    step(0, 0, 1, 2, 3, 0, 0);
    step(0, 0, 1, 2, 5, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    // DIV waits for the line to drain, then 34-cycle division
    step(0, 0, 1, 3, 4, 0, 0);
    step(0, 0, 1, 4, 5, 0, 0);
    step(0, 0, 1, 4, 5, 0, 0);
    repeat (33) step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0);
    // watchdog
    step(0, 0, 1, 4, 1, 0, 0);
    repeat (DT + 4) step(0, 0, 0, 0, 0, 0, 0);
    // flush with MULT outstanding and CSR pending
    step(0, 0, 1, 2, 6, 0, 0);
    step(0, 0, 1, 3, 7, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    // reset mid-division, illegal class held
    step(0, 0, 1, 4, 2, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 6, 0, 0, 0);
    repeat (6) step(0, 0, 1, 6, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      c = int'($urandom_range(0, 7));
      if (c == 4 && $urandom_range(0, 2) != 0) c = 3;
      step(int'($urandom_range(0, 299) == 0), int'($urandom_range(0, 29) == 0),
           int'($urandom_range(0, 3) != 0), c, int'($urandom_range(0, 7)),
           int'($urandom_range(0, 5) == 0), int'($urandom_range(0, 24) == 0));
    end
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
